// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with a two-state
// IDLE/SHIFT controller and a valid/ready load handshake.
// A word is accepted when load_valid and load_ready are both high. Its first
// bit appears on sout in the following cycle, and one further bit follows on
// each later cycle. A new word can be accepted while the last bit is on sout,
// so that frames run back to back with no gap.
// Optional feature: define PISO_SERIALIZER_PARITY_EN to append one even-parity
// bit after the data bits. frame_done then marks that parity bit.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = WIDTH + 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] din_rest;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_adv;

  // Handshake: the block is ready when idle or while the final frame bit is shown
  always_comb begin
    last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    load_ready = (state_q == ST_IDLE) || last_bit;
    accept     = load_valid && load_ready;
  end

  // Select the bit order. The register holds the bits that remain after the one on sout
  always_comb begin
    if (MSB_FIRST != 0) begin
      first_bit = din[WIDTH-1];
      din_rest  = din << 1;
      next_bit  = shreg_q[WIDTH-1];
      shreg_adv = shreg_q << 1;
    end else begin
      first_bit = din[0];
      din_rest  = din >> 1;
      next_bit  = shreg_q[0];
      shreg_adv = shreg_q >> 1;
    end
  end

  // Next-state logic: load a new frame, retire the finished frame, or advance one bit
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
`ifdef PISO_SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif
    if (accept) begin
      state_d      = ST_SHIFT;
      cnt_d        = '0;
      shreg_d      = din_rest;
      sout_d       = first_bit;
      sout_valid_d = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_d     = ^din;
`endif
    end else if (last_bit) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      shreg_d      = '0;
      sout_d       = 1'b0;
      sout_valid_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      cnt_d   = cnt_q + CW'(1);
      shreg_d = shreg_adv;
      sout_d  = next_bit;
`ifdef PISO_SERIALIZER_PARITY_EN
      if (cnt_q == LAST_DATA) begin
        sout_d = parity_q;
      end
`endif
    end
  end

  // State registers; clr_n aborts any frame in flight at once
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  // Parity of the captured word, which is presented after the last data bit
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Outputs driven from the registered state
  always_comb begin
    sout       = sout_q;
    sout_valid = sout_valid_q;
    busy       = (state_q == ST_SHIFT);
    frame_done = last_bit;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: three serializer instances (4-bit LSB-first,
// 4-bit MSB-first and 8-bit LSB-first) checked against a reference model
// of the frame bit order. The model respects PISO_SERIALIZER_PARITY_EN.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [2:0] lv = '0;
  logic [3:0] din0 = '0;
  logic [3:0] din1 = '0;
  logic [7:0] din2 = '0;
  logic [2:0] sout, sval, fdone, busy, lrdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_w4l (
    .clk(clk), .clr_n(clr_n), .din(din0), .load_valid(lv[0]), .load_ready(lrdy[0]),
    .sout(sout[0]), .sout_valid(sval[0]), .frame_done(fdone[0]), .busy(busy[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_w4m (
    .clk(clk), .clr_n(clr_n), .din(din1), .load_valid(lv[1]), .load_ready(lrdy[1]),
    .sout(sout[1]), .sout_valid(sval[1]), .frame_done(fdone[1]), .busy(busy[1]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_w8l (
    .clk(clk), .clr_n(clr_n), .din(din2), .load_valid(lv[2]), .load_ready(lrdy[2]),
    .sout(sout[2]), .sout_valid(sval[2]), .frame_done(fdone[2]), .busy(busy[2]));

  function automatic int w_of(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic bit msb_of(input int k);
    return (k == 1);
  endfunction

  // Frame bit i of a word: data bits in the chosen order, then the even parity bit
  function automatic logic exp_bit(input int k, input logic [31:0] word, input int i);
    int w = w_of(k);
    logic [31:0] m = word & ((32'h1 << w) - 32'h1);
    if (i >= w) return ^m;
    if (msb_of(k)) return m[w-1-i];
    return m[i];
  endfunction

  task automatic set_din(input int k, input logic [31:0] v);
    case (k)
      0: din0 = v[3:0];
      1: din1 = v[3:0];
      default: din2 = v[7:0];
    endcase
  endtask

  function automatic logic [4:0] observe(input int k);
    return {sout[k], sval[k], fdone[k], busy[k], lrdy[k]};
  endfunction

  // Send a list of words to instance k, checking every cycle against the model
  task automatic run_frames(input string name, input int k, input logic [31:0] words[$],
                            input bit b2b, input bit noise);
    int fl = w_of(k) + PAR;
    logic [4:0] obs, exp;
    @(negedge clk);
    for (int f = 0; f < words.size(); f++) begin
      if (f == 0 || !b2b) begin
        obs = observe(k);
        exp = 5'b00001;
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL %s idle before frame %0d: got %b expected %b (sout,valid,done,busy,ready)",
                   name, f, obs, exp);
        end
        lv[k] = 1'b1;
        set_din(k, words[f]);
        @(negedge clk);
      end
      for (int i = 0; i < fl; i++) begin
        obs = observe(k);
        exp = {exp_bit(k, words[f], i), 1'b1, (i == fl - 1), 1'b1, (i == fl - 1)};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL %s frame %0d bit %0d: got %b expected %b (sout,valid,done,busy,ready)",
                   name, f, i, obs, exp);
        end
        if (i == fl - 1) begin
          if (b2b && f + 1 < words.size()) begin
            lv[k] = 1'b1;
            set_din(k, words[f+1]);
          end else begin
            lv[k] = 1'b0;
            set_din(k, $urandom);
          end
        end else if (noise) begin
          lv[k] = 1'b1;
          set_din(k, ~words[f]);
        end else begin
          lv[k] = 1'($urandom_range(0, 1));
          set_din(k, $urandom);
        end
        @(negedge clk);
      end
    end
    obs = observe(k);
    exp = 5'b00001;
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s idle after frames: got %b expected %b (sout,valid,done,busy,ready)",
               name, obs, exp);
    end
    lv[k] = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    clr_n = 1'b0;
    #3;
    for (int k = 0; k < 3; k++) begin
      obs = observe(k);
      checks++;
      if (obs !== 5'b00001) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: got %b expected 00001", k, obs);
      end
    end
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_lsb_first();
    logic [31:0] q[$];
    q = {32'hA};
    run_frames("lsb_w4_1010", 0, q, 1'b0, 1'b0);
  endtask

  task automatic test_msb_first();
    logic [31:0] q[$];
    q = {32'hC};
    run_frames("msb_w4_1100", 1, q, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    q = {32'hA5, 32'h3C};
    run_frames("b2b_a5_3c", 2, q, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_load();
    logic [31:0] q[$];
    q = {32'h0};
    run_frames("ignore_midframe_load", 0, q, 1'b0, 1'b1);
  endtask

  task automatic test_parity();
    logic [31:0] q[$];
    q = {32'h7};
    run_frames("parity_w4_0111", 0, q, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    for (int r = 0; r < 12; r++) begin
      q.delete();
      for (int n = 0; n < $urandom_range(1, 3); n++) q.push_back($urandom);
      run_frames("random", r % 3, q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] word, nxt;
    logic [31:0] q[$];
    logic [4:0]  obs, exp;
    word = $urandom;
    @(negedge clk);
    lv[2] = 1'b1;
    set_din(2, word);
    @(negedge clk);
    lv[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs = observe(2);
      exp = {exp_bit(2, word, i), 1'b1, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset_mid bit %0d: got %b expected %b", i, obs, exp);
      end
      if (i < 3) @(negedge clk);
    end
    clr_n = 1'b0;
    #1;
    obs = observe(2);
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset_mid async clear: got %b expected 00001", obs);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs = observe(2);
      checks++;
      if (obs !== 5'b00001) begin
        errors++;
        $display("[TB] FAIL reset_mid held cycle %0d: got %b expected 00001", c, obs);
      end
    end
    clr_n = 1'b1;
    nxt = $urandom;
    q = {nxt};
    run_frames("after_reset", 2, q, 1'b0, 1'b0);
  endtask

  // Watchdog so that a stuck run still ends with a report
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_ignore_load();
    test_parity();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0; 0 = LSB shifted out first, 1 = MSB first.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 clr_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  WIDTH  parallel word to serialise.
REQ-006 load_valid  input  1  din holds a word to load.
REQ-007 load_ready  output  1  block accepts a word this cycle.
REQ-008 sout  output  1  serial data bit, registered.
REQ-009 sout_valid  output  1  sout carries a frame bit this cycle, registered.
REQ-010 frame_done  output  1  one-cycle pulse coincident with the last frame bit.
REQ-011 busy  output  1  high while in SHIFT state.

Function
REQ-012 Two-state FSM: IDLE, SHIFT.
REQ-013 Frame length FL = WIDTH, or WIDTH+1 with parity (REQ-027).
REQ-014 Load accepted on a rising edge where load_valid and load_ready are both high; din captured into the internal shift register, bit counter cleared to 0, FSM to SHIFT.
REQ-015 load_ready is high in IDLE, and in SHIFT only during the cycle the last frame bit is presented (counter = FL-1); low otherwise.
REQ-016 Latency: first frame bit on sout, with sout_valid high, in the cycle after acceptance.
REQ-017 In SHIFT, each cycle presents one bit: din[0] upward when MSB_FIRST=0, din[WIDTH-1] downward when MSB_FIRST=1; counter increments by 1 per cycle.
REQ-018 frame_done is high exactly in the cycle the bit at counter = FL-1 is presented.
REQ-019 End of frame without a new load: FSM to IDLE; sout = 0, sout_valid = 0, busy = 0 from the next cycle.
REQ-020 Back-to-back: a load accepted during the last-bit cycle starts the next frame in the next cycle with no gap; sout_valid stays high and busy stays high.
REQ-021 load_valid while load_ready is low is ignored; din changes mid-frame do not affect the frame in flight.
REQ-022 Counter width $clog2(WIDTH+2); the counter never exceeds FL-1.
REQ-023 In IDLE, sout and sout_valid are 0.

Reset
REQ-024 clr_n low asynchronously forces IDLE, counter 0, shift register 0, sout 0, sout_valid 0, frame_done 0, busy 0, load_ready 1.
REQ-025 Reset asserted mid-frame aborts the frame; no further frame bits and no frame_done are produced for it.
REQ-026 After clr_n deasserts, a load is accepted on the first rising edge that has load_valid high.

Configuration
REQ-027 Macro PISO_SERIALIZER_PARITY_EN defined: FL = WIDTH+1; after the last data bit, one even-parity bit (XOR of the captured word) is presented with sout_valid high; frame_done coincides with the parity bit.
REQ-028 Macro PISO_SERIALIZER_PARITY_EN undefined: FL = WIDTH; no parity logic is present; frame_done coincides with the last data bit.

Verification
REQ-029 WIDTH=4, MSB_FIRST=0, load din=4'b1010 -> sout 0,1,0,1 over the next 4 cycles with sout_valid high; frame_done on the 4th cycle; idle afterwards.
REQ-030 WIDTH=4, MSB_FIRST=1, load 4'b1100 -> sout 1,1,0,0; busy high for exactly 4 cycles.
REQ-031 Back-to-back: 8'hA5 then 8'h3C with the second load_valid held high -> 16 contiguous valid bits (LSB first: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0); two frame_done pulses, 8 cycles apart.
REQ-032 load_valid pulsed with din=4'hF at bit 2 of a frame carrying 4'h0 -> ignored; output stays 0,0,0,0; load_ready low at that cycle.
REQ-033 clr_n pulsed low at bit 3 of an 8-bit frame -> sout/sout_valid/busy 0 immediately (before the next clock edge); no frame_done; the next load serialises correctly.
REQ-034 PISO_SERIALIZER_PARITY_EN defined, WIDTH=4, load 4'b0111 -> sout 1,1,1,0 then parity 1; frame_done on the 5th bit.
